// File: rtl/gpio_dec_display.sv
// rtl/gpio_dec_display.sv - decimal seven-segment driver for the gpio_out bus
// Sequential double-dabble (one shift per cycle) feeding registered BCD and segment outputs.
module gpio_dec_display #(
  parameter int NDIGITS       = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            value_in,
  output logic [7*NDIGITS-1:0]   hex_out,
  output logic [4*NDIGITS-1:0]   bcd_out,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            bin_q;
  logic [39:0]            acc_q;
  logic [4:0]             cnt_q;
  logic [31:0]            shown_q;
  logic                   shown_valid_q;
  logic [7*NDIGITS-1:0]   hex_q;
  logic [4*NDIGITS-1:0]   bcd_q;
  logic                   ovf_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   change_c;
  logic                   load_c;
  logic                   shift_c;
  logic                   update_c;
  logic [39:0]            adj_c;
  logic                   ovf_c;
  logic [7*NDIGITS-1:0]   hex_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign change_c = (value_in != shown_q) || !shown_valid_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (change_c) state_d = SHIFT;
      SHIFT:   if (cnt_q == 5'd0) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    update_c = 1'b0;
    case (state_q)
      IDLE:    load_c   = change_c;
      SHIFT:   shift_c  = 1'b1;
      UPDATE:  update_c = 1'b1;
      default: ;
    endcase
  end

  // add-3 correction on every nibble before each shift
  always_comb begin
    adj_c = '0;
    for (int k = 0; k < 10; k++) begin
      adj_c[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    end
  end

  always_comb begin
    ovf_c = 1'b0;
    for (int k = NDIGITS; k < 10; k++) begin
      ovf_c = ovf_c | (|acc_q[4*k +: 4]);
    end
  end

  // walk from the top digit down; blanking stops at the first non-zero digit
  always_comb begin
    logic lead;
    hex_c = '1;
    lead  = (BLANK_LEADING != 0) && !ovf_c;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      if (lead && (i > 0) && (acc_q[4*i +: 4] == 4'd0)) begin
        hex_c[7*i +: 7] = 7'b1111111;
      end else begin
        hex_c[7*i +: 7] = seg7(acc_q[4*i +: 4]);
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      shown_q       <= '0;
      shown_valid_q <= 1'b0;
      hex_q         <= '1;
      bcd_q         <= '0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_c) begin
        bin_q   <= value_in;
        shown_q <= value_in;
        acc_q   <= '0;
        cnt_q   <= 5'd31;
        busy_q  <= 1'b1;
      end
      if (shift_c) begin
        acc_q <= {adj_c[38:0], bin_q[31]};
        bin_q <= {bin_q[30:0], 1'b0};
        cnt_q <= cnt_q - 5'd1;
      end
      if (update_c) begin
        bcd_q         <= acc_q[4*NDIGITS-1:0];
        ovf_q         <= ovf_c;
        hex_q         <= hex_c;
        shown_valid_q <= 1'b1;
        done_q        <= 1'b1;
        busy_q        <= 1'b0;
      end
    end
  end

  assign hex_out  = hex_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gpio_dec_display.sv
// tb/tb_gpio_dec_display.sv - self-checking bench for gpio_dec_display
// Two instances (blanking on/off) share inputs; expectations come from arithmetic digit extraction.
module tb_gpio_dec_display;
  localparam int ND = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       value_in;
  logic [7*ND-1:0]   hex1, hex0b;
  logic [4*ND-1:0]   bcd1, bcd0b;
  logic              ovf1, ovf0b, busy1, busy0b, done1, done0b;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  gpio_dec_display #(.NDIGITS(ND), .BLANK_LEADING(1)) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in), .hex_out(hex1), .bcd_out(bcd1),
    .overflow(ovf1), .busy(busy1), .done(done1));

  gpio_dec_display #(.NDIGITS(ND), .BLANK_LEADING(0)) u_dut_nb (
    .clk(clk), .rst(rst), .value_in(value_in), .hex_out(hex0b), .bcd_out(bcd0b),
    .overflow(ovf0b), .busy(busy0b), .done(done0b));

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] m_bcd(input logic [31:0] v);
    longint x = v;
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic m_ovf(input logic [31:0] v);
    longint p = 1;
    for (int i = 0; i < ND; i++) p = p * 10;
    return longint'(v) >= p;
  endfunction

  function automatic logic [7*ND-1:0] m_hex(input logic [31:0] v, input logic blank);
    longint x = v;
    int dig [ND];
    int msd = 0;
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++) begin
      dig[i] = int'(x % 10);
      x = x / 10;
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (blank && !m_ovf(v) && i > msd) r[7*i +: 7] = 7'b1111111;
      else                               r[7*i +: 7] = seg_tab[dig[i]];
    end
    return r;
  endfunction

  task automatic wait_done(input int budget, output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < budget && !ok) begin
      @(negedge clk);
      lat++;
      if (done1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lat; logic ok;
    @(negedge clk);
    rst = 1'b1; value_in = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (hex1 !== '1 || busy1 !== 1'b0 || done1 !== 1'b0 || bcd1 !== '0 || ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: hex=%h busy=%b done=%b bcd=%h ovf=%b required hex=all1 busy=0 done=0 bcd=0 ovf=0",
               hex1, busy1, done1, bcd1, ovf1);
    end
    rst = 1'b0;
    wait_done(60, lat, ok);
    n_cmp++;
    if (!ok || lat != 34) begin
      n_err++;
      $display("FAIL reset_latency: done seen=%b after %0d cycles, required 34", ok, lat);
    end
    n_cmp++;
    if (bcd1 !== m_bcd(0) || hex1 !== m_hex(0, 1) || ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_zero: bcd=%h hex=%h ovf=%b required bcd=%h hex=%h ovf=0",
               bcd1, hex1, ovf1, m_bcd(0), m_hex(0, 1));
    end
  endtask

  task automatic test_hold();
    int lat; logic ok; int extra;
    value_in = 32'd12345678;
    wait_done(60, lat, ok);
    n_cmp++;
    if (!ok || lat != 34) begin
      n_err++;
      $display("FAIL hold_latency: done seen=%b after %0d cycles, required 34", ok, lat);
    end
    n_cmp++;
    if (bcd1 !== 32'h12345678 || hex1 !== m_hex(32'd12345678, 1) || ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL hold_value: bcd=%h hex=%h ovf=%b required bcd=12345678 hex=%h ovf=0",
               bcd1, hex1, ovf1, m_hex(32'd12345678, 1));
    end
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done1 || busy1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL hold_no_redone: %0d cycles with done/busy while held, required 0", extra);
    end
  endtask

  task automatic test_value(input logic [31:0] v, input string name);
    int lat; logic ok;
    value_in = v;
    wait_done(60, lat, ok);
    n_cmp++;
    if (!ok || lat != 34 || done0b !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: done seen=%b after %0d cycles (nb done=%b), required 34", name, ok, lat, done0b);
    end
    n_cmp++;
    if (bcd1 !== m_bcd(v) || ovf1 !== m_ovf(v) || hex1 !== m_hex(v, 1)) begin
      n_err++;
      $display("FAIL %s_blank: v=%0d bcd=%h ovf=%b hex=%h required bcd=%h ovf=%b hex=%h",
               name, v, bcd1, ovf1, hex1, m_bcd(v), m_ovf(v), m_hex(v, 1));
    end
    n_cmp++;
    if (bcd0b !== m_bcd(v) || ovf0b !== m_ovf(v) || hex0b !== m_hex(v, 0)) begin
      n_err++;
      $display("FAIL %s_noblank: v=%0d bcd=%h ovf=%b hex=%h required bcd=%h ovf=%b hex=%h",
               name, v, bcd0b, ovf0b, hex0b, m_bcd(v), m_ovf(v), m_hex(v, 0));
    end
  endtask

  task automatic test_change_mid();
    int ndone = 0; int bad = 0;
    logic [4*ND-1:0] last = '0;
    value_in = 32'd100;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL change_busy: busy=%b required 1", busy1);
    end
    value_in = 32'd250;
    repeat (150) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        last = bcd1;
        if (!((bcd1 === m_bcd(100) && hex1 === m_hex(100, 1)) ||
              (bcd1 === m_bcd(250) && hex1 === m_hex(250, 1)))) bad++;
      end
    end
    n_cmp++;
    if (bad != 0 || ndone < 1 || ndone > 2) begin
      n_err++;
      $display("FAIL change_dones: %0d dones, %0d mixed, required 1..2 dones and 0 mixed", ndone, bad);
    end
    n_cmp++;
    if (last !== m_bcd(250) || hex1 !== m_hex(250, 1)) begin
      n_err++;
      $display("FAIL change_final: bcd=%h hex=%h required bcd=%h hex=%h", last, hex1, m_bcd(250), m_hex(250, 1));
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic ok;
    value_in = 32'd99;
    repeat (16) @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy_before: busy=%b required 1", busy1);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || hex1 !== '1 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: busy=%b hex=%h done=%b required busy=0 hex=all1 done=0", busy1, hex1, done1);
    end
    rst = 1'b0;
    wait_done(60, lat, ok);
    n_cmp++;
    if (!ok || lat != 34 || bcd1 !== 32'h00000099 || hex1 !== m_hex(99, 1)) begin
      n_err++;
      $display("FAIL rstmid_redo: done=%b lat=%0d bcd=%h hex=%h required lat=34 bcd=00000099 hex=%h",
               ok, lat, bcd1, hex1, m_hex(99, 1));
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] prev = value_in;
    for (int n = 0; n < 24; n++) begin
      v = $urandom;
      v = v >> $urandom_range(0, 31);
      if (v == prev) v = v ^ 32'd1;
      test_value(v, "random");
      prev = v;
    end
  endtask

  task automatic test_back_to_back();
    test_value(32'd1, "b2b_one");
    test_value(32'd10, "b2b_ten");
    test_value(32'd0, "b2b_zero");
  endtask

  initial begin
    rst = 1'b1;
    value_in = '0;
    test_reset();
    test_hold();
    test_value(32'hFFFFFFFF, "max");
    test_value(32'd7, "seven");
    test_value(32'd99999999, "edge_below");
    test_value(32'd100000000, "edge_over");
    test_change_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
